// File: rtl/hashcam_req_sequencer.sv
// Request sequencer for the hash CAM: buffers lookup/write requests, replays each as the CAM's
// level enable/ready handshake through synchronised ready lines, and returns one response per request.
module hashcam_req_sequencer #(
    parameter int unsigned KEY_WIDTH_IN_OCTETS = 2,
    parameter int unsigned VALUE_WIDTH_IN_BITS = 8,
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES      = 64
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_op,
    input  logic [KEY_WIDTH_IN_OCTETS*8-1:0] req_key,
    input  logic [VALUE_WIDTH_IN_BITS-1:0] req_value,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic                           resp_op,
    output logic                           resp_match,
    output logic                           resp_full,
    output logic                           resp_timeout,
    output logic [VALUE_WIDTH_IN_BITS-1:0] resp_value,
    output logic                           cam_lookup_enable,
    output logic                           cam_write_enable,
    output logic [KEY_WIDTH_IN_OCTETS*8-1:0] cam_key,
    output logic [VALUE_WIDTH_IN_BITS-1:0] cam_value,
    input  logic                           cam_lookup_ready,
    input  logic                           cam_write_ready,
    input  logic                           cam_match,
    input  logic                           cam_full,
    input  logic [VALUE_WIDTH_IN_BITS-1:0] cam_value_out,
    output logic [7:0]                     timeout_count
);

    localparam int unsigned KW = KEY_WIDTH_IN_OCTETS * 8;
    localparam int unsigned VW = VALUE_WIDTH_IN_BITS;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 1 + KW + VW;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT_RDY,
        S_RELEASE,
        S_RESP
    } state_e;

    // Request FIFO storage and pointers
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          req_ready_q;
    logic          push_c, pop_c, fifo_empty_c;
    logic [EW-1:0] fifo_head_c;

    logic [1:0] lrdy_sync_q, wrdy_sync_q;
    logic       rdy_s_c;

    state_e        state_q, state_d;
    logic          op_q, op_d;
    logic [KW-1:0] key_q, key_d;
    logic [VW-1:0] value_q, value_d;
    logic          len_q, len_d, wen_q, wen_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          rvalid_q, rvalid_d;
    logic          rmatch_q, rmatch_d;
    logic          rfull_q, rfull_d;
    logic          rtmo_q, rtmo_d;
    logic [VW-1:0] rvalue_q, rvalue_d;
    logic [7:0]    tcnt_q, tcnt_d;

    assign push_c       = req_valid & req_ready_q;
    assign fifo_empty_c = (count_q == '0);
    assign fifo_head_c  = mem_q[rd_ptr_q];
    assign count_d      = count_q + CW'(push_c) - CW'(pop_c);
    assign rdy_s_c      = op_q ? wrdy_sync_q[1] : lrdy_sync_q[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            req_ready_q <= 1'b1;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= {req_op, req_key, req_value};
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q     <= count_d;
            req_ready_q <= (count_d != CW'(FIFO_DEPTH));
        end
    end

    // Ready lines come from the clockless CAM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lrdy_sync_q <= '0;
            wrdy_sync_q <= '0;
        end else begin
            lrdy_sync_q <= {lrdy_sync_q[0], cam_lookup_ready};
            wrdy_sync_q <= {wrdy_sync_q[0], cam_write_ready};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            key_q    <= '0;
            value_q  <= '0;
            len_q    <= 1'b0;
            wen_q    <= 1'b0;
            tmr_q    <= '0;
            rvalid_q <= 1'b0;
            rmatch_q <= 1'b0;
            rfull_q  <= 1'b0;
            rtmo_q   <= 1'b0;
            rvalue_q <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            key_q    <= key_d;
            value_q  <= value_d;
            len_q    <= len_d;
            wen_q    <= wen_d;
            tmr_q    <= tmr_d;
            rvalid_q <= rvalid_d;
            rmatch_q <= rmatch_d;
            rfull_q  <= rfull_d;
            rtmo_q   <= rtmo_d;
            rvalue_q <= rvalue_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        key_d    = key_q;
        value_d  = value_q;
        len_d    = len_q;
        wen_d    = wen_q;
        tmr_d    = tmr_q;
        rvalid_d = rvalid_q;
        rmatch_d = rmatch_q;
        rfull_d  = rfull_q;
        rtmo_d   = rtmo_q;
        rvalue_d = rvalue_q;
        tcnt_d   = tcnt_q;
        pop_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c                  = 1'b1;
                    {op_d, key_d, value_d} = fifo_head_c;
                    rmatch_d               = 1'b0;
                    rfull_d                = 1'b0;
                    rtmo_d                 = 1'b0;
                    rvalue_d               = '0;
                    state_d                = S_SETUP;
                end
            end
            S_SETUP: begin
                len_d   = ~op_q;
                wen_d   = op_q;
                tmr_d   = '0;
                state_d = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (rdy_s_c) begin
                    rmatch_d = cam_match;
                    rfull_d  = cam_full;
                    rvalue_d = cam_value_out;
                    len_d    = 1'b0;
                    wen_d    = 1'b0;
                    tmr_d    = '0;
                    state_d  = S_RELEASE;
                end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    len_d    = 1'b0;
                    wen_d    = 1'b0;
                    rtmo_d   = 1'b1;
                    rmatch_d = 1'b0;
                    rfull_d  = 1'b0;
                    rvalue_d = '0;
                    if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    tmr_d    = '0;
                    state_d  = S_RELEASE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_RELEASE: begin
                // A ready that never drops still yields a response, flagged as a timeout
                if (!rdy_s_c) begin
                    rvalid_d = 1'b1;
                    state_d  = S_RESP;
                end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    rvalid_d = 1'b1;
                    rtmo_d   = 1'b1;
                    if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'd1;
                    state_d  = S_RESP;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = rvalid_q;
    assign resp_op           = op_q;
    assign resp_match        = rmatch_q;
    assign resp_full         = rfull_q;
    assign resp_timeout      = rtmo_q;
    assign resp_value        = rvalue_q;
    assign cam_lookup_enable = len_q;
    assign cam_write_enable  = wen_q;
    assign cam_key           = key_q;
    assign cam_value         = value_q;
    assign timeout_count     = tcnt_q;

endmodule

// File: tb/tb_hashcam_req_sequencer.sv
// Directed bench for hashcam_req_sequencer with a small behavioural CAM whose ready can be withheld.
module tb_hashcam_req_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_op = 1'b0;
    logic [15:0] req_key = '0;
    logic [7:0]  req_value = '0;
    logic        resp_valid, resp_ready = 1'b1, resp_op, resp_match, resp_full, resp_timeout;
    logic [7:0]  resp_value;
    logic        cam_lookup_enable, cam_write_enable;
    logic [15:0] cam_key;
    logic [7:0]  cam_value;
    logic        cam_lookup_ready, cam_write_ready;
    logic        cam_match = 1'b0, cam_full = 1'b0;
    logic [7:0]  cam_value_out = '0;
    logic [7:0]  timeout_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       op;
        logic       match;
        logic       full;
        logic       tmo;
        logic [7:0] val;
    } resp_t;

    resp_t resp_q[$];
    int    both_en = 0;
    int    stall_cycles = 0;
    int    en_cycles = 0;
    logic  cam_rdy_en = 1'b1;

    hashcam_req_sequencer #(
        .KEY_WIDTH_IN_OCTETS(2),
        .VALUE_WIDTH_IN_BITS(8),
        .FIFO_DEPTH(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_value(req_value),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
        .resp_match(resp_match), .resp_full(resp_full), .resp_timeout(resp_timeout),
        .resp_value(resp_value),
        .cam_lookup_enable(cam_lookup_enable), .cam_write_enable(cam_write_enable),
        .cam_key(cam_key), .cam_value(cam_value),
        .cam_lookup_ready(cam_lookup_ready), .cam_write_ready(cam_write_ready),
        .cam_match(cam_match), .cam_full(cam_full), .cam_value_out(cam_value_out),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: results settle on the enable's rising edge, ready follows enable
    logic [15:0] ck[8];
    logic [7:0]  cv[8];
    logic        cu[8];
    initial for (int i = 0; i < 8; i++) begin ck[i] = '0; cv[i] = '0; cu[i] = 1'b0; end

    assign cam_lookup_ready = cam_lookup_enable & cam_rdy_en;
    assign cam_write_ready  = cam_write_enable & cam_rdy_en;

    always @(posedge cam_lookup_enable) begin
        cam_match = 1'b0;
        cam_value_out = '0;
        for (int i = 0; i < 8; i++)
            if (cu[i] && ck[i] == cam_key) begin cam_match = 1'b1; cam_value_out = cv[i]; end
    end

    always @(posedge cam_write_enable) begin
        logic done;
        cam_match = 1'b0;
        cam_value_out = '0;
        done = 1'b0;
        for (int i = 0; i < 8; i++)
            if (cu[i] && ck[i] == cam_key) begin
                cam_match = 1'b1; cam_value_out = cv[i]; cv[i] = cam_value; done = 1'b1;
            end
        for (int i = 0; i < 8; i++)
            if (!done && !cu[i]) begin cu[i] = 1'b1; ck[i] = cam_key; cv[i] = cam_value; done = 1'b1; end
    end

    always @(negedge clk) begin
        if (resp_valid && resp_ready)
            resp_q.push_back({resp_op, resp_match, resp_full, resp_timeout, resp_value});
        if (cam_lookup_enable && cam_write_enable) both_en <= both_en + 1;
        if (cam_lookup_enable || cam_write_enable) en_cycles <= en_cycles + 1;
        if (req_valid && !req_ready) stall_cycles <= stall_cycles + 1;
    end

    task automatic push_req(input logic op, input logic [15:0] key, input logic [7:0] val);
        int n = 0;
        req_op = op; req_key = key; req_value = val; req_valid = 1'b1;
        while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL push_accept key=%h req_ready=%b required 1 within 200 cycles", key, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resps(input int n);
        int c = 0;
        while (resp_q.size() < n && c < 300) begin @(negedge clk); c++; end
        if (resp_q.size() < n) begin
            checks++; errors++;
            $display("FAIL resp_count got %0d required %0d", resp_q.size(), n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if ({cam_lookup_enable, cam_write_enable} !== 2'b00) begin errors++; $display("FAIL reset_enables got %b exp 00", {cam_lookup_enable, cam_write_enable}); end
        checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL reset_timeout_count got %0d exp 0", timeout_count); end
        checks++; if ({cam_key, cam_value, resp_value} !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {cam_key, cam_value, resp_value}); end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_lookup();
        resp_t exp[3];
        exp[0] = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        exp[1] = {1'b0, 1'b1, 1'b0, 1'b0, 8'hAB};
        exp[2] = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        resp_q.delete();
        resp_ready = 1'b1;
        push_req(1'b1, 16'h1234, 8'hAB);
        wait_resps(1);
        push_req(1'b0, 16'h1234, 8'h00);
        wait_resps(2);
        push_req(1'b0, 16'h5678, 8'h00);
        wait_resps(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (resp_q[i] !== exp[i]) begin errors++; $display("FAIL write_lookup[%0d] got %h exp %h", i, resp_q[i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        resp_t exp[6];
        int b0 = both_en;
        int s0 = stall_cycles;
        exp[0] = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        exp[1] = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        exp[2] = {1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
        exp[3] = {1'b1, 1'b1, 1'b0, 1'b0, 8'h11};
        exp[4] = {1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
        exp[5] = {1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        resp_q.delete();
        resp_ready = 1'b1;
        push_req(1'b1, 16'h0001, 8'h11);
        push_req(1'b1, 16'h0002, 8'h22);
        push_req(1'b0, 16'h0001, 8'h00);
        push_req(1'b1, 16'h0001, 8'h33);
        push_req(1'b0, 16'h0001, 8'h00);
        push_req(1'b0, 16'h0003, 8'h00);
        wait_resps(6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (resp_q[i] !== exp[i]) begin errors++; $display("FAIL b2b[%0d] got %h exp %h", i, resp_q[i], exp[i]); end
        end
        checks++; if (stall_cycles == s0) begin errors++; $display("FAIL b2b_backpressure stall cycles %0d exp >0", stall_cycles - s0); end
        checks++; if (both_en != b0) begin errors++; $display("FAIL b2b_one_enable overlap cycles %0d exp 0", both_en - b0); end
    endtask

    task automatic test_timeout();
        int t_en = -1;
        int t_v = -1;
        resp_q.delete();
        resp_ready = 1'b1;
        cam_rdy_en = 1'b0;
        push_req(1'b0, 16'h1234, 8'h00);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (t_en < 0 && cam_lookup_enable) t_en = i;
            if (resp_valid) begin t_v = i; break; end
        end
        checks++;
        if (t_en < 0 || t_v < 0 || (t_v - t_en) < 16 || (t_v - t_en) > 17) begin
            errors++; $display("FAIL tmo_latency enable->valid %0d cycles exp 16..17 (t_en=%0d t_v=%0d)", t_v - t_en, t_en, t_v);
        end
        checks++; if ({resp_timeout, resp_match, resp_full, resp_value} !== {3'b100, 8'h00}) begin
            errors++; $display("FAIL tmo_fields got t%b m%b f%b v%h exp t1 m0 f0 v00", resp_timeout, resp_match, resp_full, resp_value);
        end
        checks++; if (timeout_count !== 8'd1) begin errors++; $display("FAIL tmo_count got %0d exp 1", timeout_count); end
        cam_rdy_en = 1'b1;
        wait_resps(1);
        push_req(1'b0, 16'h0002, 8'h00);
        wait_resps(2);
        checks++; if (resp_q[1] !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h22}) begin
            errors++; $display("FAIL tmo_next got %h exp %h", resp_q[1], {1'b0, 1'b1, 1'b0, 1'b0, 8'h22});
        end
        checks++; if (timeout_count !== 8'd1) begin errors++; $display("FAIL tmo_count_after got %0d exp 1", timeout_count); end
    endtask

    task automatic test_stall();
        resp_t exp[5];
        resp_t snap;
        int changes = 0;
        int c = 0;
        exp[0] = {1'b0, 1'b1, 1'b0, 1'b0, 8'h22};
        exp[1] = {1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        exp[2] = {1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
        exp[3] = {1'b1, 1'b1, 1'b0, 1'b0, 8'h22};
        exp[4] = {1'b0, 1'b1, 1'b0, 1'b0, 8'h55};
        resp_q.delete();
        resp_ready = 1'b0;
        push_req(1'b0, 16'h0002, 8'h00);
        while (!resp_valid && c < 100) begin @(negedge clk); c++; end
        snap = {resp_op, resp_match, resp_full, resp_timeout, resp_value};
        push_req(1'b1, 16'h0004, 8'h44);
        push_req(1'b0, 16'h0004, 8'h00);
        push_req(1'b1, 16'h0002, 8'h55);
        push_req(1'b0, 16'h0002, 8'h00);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!resp_valid || {resp_op, resp_match, resp_full, resp_timeout, resp_value} !== snap) changes++;
        end
        checks++; if (snap !== exp[0]) begin errors++; $display("FAIL stall_first got %h exp %h", snap, exp[0]); end
        checks++; if (changes != 0) begin errors++; $display("FAIL stall_hold changed %0d cycles exp 0", changes); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_fifo_full req_ready %b exp 0", req_ready); end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_resps(5);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_q[i] !== exp[i]) begin errors++; $display("FAIL stall_order[%0d] got %h exp %h", i, resp_q[i], exp[i]); end
        end
    endtask

    task automatic test_full_flag();
        resp_q.delete();
        resp_ready = 1'b1;
        cam_full = 1'b1;
        push_req(1'b0, 16'h0004, 8'h00);
        wait_resps(1);
        cam_full = 1'b0;
        checks++; if (resp_q[0] !== {1'b0, 1'b1, 1'b1, 1'b0, 8'h44}) begin
            errors++; $display("FAIL full_flag got %h exp %h", resp_q[0], {1'b0, 1'b1, 1'b1, 1'b0, 8'h44});
        end
    endtask

    task automatic test_reset_midflight();
        int c = 0;
        int e0;
        resp_q.delete();
        resp_ready = 1'b1;
        cam_rdy_en = 1'b0;
        push_req(1'b0, 16'h0004, 8'h00);
        while (!cam_lookup_enable && c < 50) begin @(negedge clk); c++; end
        push_req(1'b1, 16'h0009, 8'h99);
        push_req(1'b0, 16'h0009, 8'h00);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        checks++; if ({cam_lookup_enable, cam_write_enable, resp_valid} !== 3'b000) begin
            errors++; $display("FAIL rst_async en/valid got %b exp 000", {cam_lookup_enable, cam_write_enable, resp_valid});
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
        checks++; if (timeout_count !== 8'd0) begin errors++; $display("FAIL rst_timeout_count got %0d exp 0", timeout_count); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cam_rdy_en = 1'b1;
        e0 = en_cycles;
        repeat (30) @(negedge clk);
        checks++; if (en_cycles != e0 || resp_q.size() != 0) begin
            errors++; $display("FAIL rst_fifo_flushed enable cycles %0d responses %0d exp 0 0", en_cycles - e0, resp_q.size());
        end
        @(posedge clk); #1;
        push_req(1'b0, 16'h0009, 8'h00);
        wait_resps(1);
        checks++; if (resp_q[0] !== {1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL rst_discarded_write got %h exp %h", resp_q[0], {1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        end
    endtask

    initial begin
        test_reset();
        test_write_lookup();
        test_back_to_back();
        test_timeout();
        test_stall();
        test_full_flag();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
